led_flow_pwm: RTL and testbench

//   Parametrised N-channel flowing-LED driver with programmable on-time.
//   One free-running period counter; once per period the lit position steps to
//   the next LED. The lit LED is on for the first `duty` clocks of each period.

---
 rtl/led_flow_pwm_if.sv | 27 ++
 rtl/led_flow_pwm.sv | 109 ++++++++++
 tb/tb_led_flow_pwm.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/led_flow_pwm_if.sv
// Control/drive bundle between the board-side controller and the flowing-LED driver.
interface led_flow_pwm_if #(
    parameter int N_LED = 4,
    parameter int CNT_W = 23
);
    logic             EN;
    logic             DIR;
    logic [CNT_W-1:0] duty;
    logic [N_LED-1:0] LED_out;
    logic             step;

    modport master (
        output EN,
        output DIR,
        output duty,
        input  LED_out,
        input  step
    );

    modport slave (
        input  EN,
        input  DIR,
        input  duty,
        output LED_out,
        output step
    );
endinterface

// File: rtl/led_flow_pwm.sv
// N-channel flowing-LED PWM driver; LED_out/step registered one clock behind the counter, EN=0 freezes state.
// Define LED_FLOW_PINGPONG_EN for bounce-at-the-ends stepping (DIR ignored); default is wrap-around per DIR.
module led_flow_pwm #(
    parameter int N_LED    = 4,
    parameter int CNT_W    = 23,
    parameter int PERIOD   = 5_000_000,
    parameter int DUTY_RST = 1_250_000
) (
    input  logic          CLK,
    input  logic          RST,
    led_flow_pwm_if.slave bus
);
    localparam int POS_W = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DUTY_INIT = CNT_W'(DUTY_RST);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(N_LED - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] duty_q, duty_nxt;
    logic [POS_W-1:0] pos, pos_nxt;
    logic [N_LED-1:0] led_q, led_nxt;
    logic             step_q, step_nxt;
    logic             wrap;

`ifdef LED_FLOW_PINGPONG_EN
    typedef enum logic {FLOW_UP = 1'b0, FLOW_DN = 1'b1} flow_dir_t;
    flow_dir_t flow_dir, flow_dir_nxt;
    logic      unused_dir;

    assign unused_dir = bus.DIR;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flow_dir <= FLOW_UP;
        end else begin
            flow_dir <= flow_dir_nxt;
        end
    end
`endif

    assign wrap = bus.EN && (cnt == CNT_LAST);

    always_comb begin
        cnt_nxt  = cnt;
        duty_nxt = duty_q;
        pos_nxt  = pos;
        step_nxt = wrap;
        led_nxt  = '0;
`ifdef LED_FLOW_PINGPONG_EN
        flow_dir_nxt = flow_dir;
`endif

        if (bus.EN) begin
            cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
        end

        if (wrap) begin
            duty_nxt = bus.duty;
`ifdef LED_FLOW_PINGPONG_EN
            // Bounce off either end instead of re-lighting the end LED twice.
            if (flow_dir == FLOW_UP) begin
                if (pos == POS_LAST) begin
                    flow_dir_nxt = FLOW_DN;
                    pos_nxt      = pos - POS_W'(1);
                end else begin
                    pos_nxt = pos + POS_W'(1);
                end
            end else begin
                if (pos == '0) begin
                    flow_dir_nxt = FLOW_UP;
                    pos_nxt      = POS_W'(1);
                end else begin
                    pos_nxt = pos - POS_W'(1);
                end
            end
`else
            if (bus.DIR) begin
                pos_nxt = (pos == '0) ? POS_LAST : pos - POS_W'(1);
            end else begin
                pos_nxt = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
            end
`endif
        end

        // Uses the pre-edge cnt/pos, so the lit window trails the counter by one clock.
        for (int i = 0; i < N_LED; i++) begin
            led_nxt[i] = bus.EN && (pos == POS_W'(i)) && (cnt < duty_q);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            pos    <= '0;
            duty_q <= DUTY_INIT;
            led_q  <= '0;
            step_q <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            pos    <= pos_nxt;
            duty_q <= duty_nxt;
            led_q  <= led_nxt;
            step_q <= step_nxt;
        end
    end

    assign bus.LED_out = led_q;
    assign bus.step    = step_q;
endmodule

// File: tb/tb_led_flow_pwm.sv
// Directed bench for led_flow_pwm with N_LED=4, PERIOD=10, CNT_W=4, DUTY_RST=3.
module tb_led_flow_pwm;
    localparam int N_LED    = 4;
    localparam int CNT_W    = 4;
    localparam int PERIOD   = 10;
    localparam int DUTY_RST = 3;

`ifdef LED_FLOW_PINGPONG_EN
    localparam int NP1      = 8;
    localparam int P_AFTER3 = 2;
    int seq1 [NP1] = '{0, 1, 2, 3, 2, 1, 0, 1};
`else
    localparam int NP1      = 5;
    localparam int P_AFTER3 = 0;
    int seq1 [NP1] = '{0, 1, 2, 3, 0};
    int seq2 [4]   = '{0, 3, 2, 1};
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    led_flow_pwm_if #(.N_LED(N_LED), .CNT_W(CNT_W)) bus ();

    led_flow_pwm #(
        .N_LED   (N_LED),
        .CNT_W   (CNT_W),
        .PERIOD  (PERIOD),
        .DUTY_RST(DUTY_RST)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks through pre-edge counter values k0..k1 of a period with lit position p and duty d.
    task automatic cyc(input string tag, input int p, input int d, input int k0, input int k1);
        logic [3:0] exp_led;
        for (int k = k0; k <= k1; k++) begin
            tick();
            exp_led = (k < d) ? 4'(1 << p) : 4'b0000;
            check($sformatf("%s led p=%0d k=%0d", tag, p, k), 32'(bus.LED_out), 32'(exp_led));
            check($sformatf("%s step p=%0d k=%0d", tag, p, k), 32'(bus.step), 32'(k == PERIOD - 1));
        end
    endtask

    task automatic do_reset(input logic dir, input logic [CNT_W-1:0] d);
        rst      = 1'b1;
        bus.EN   = 1'b0;
        bus.DIR  = dir;
        bus.duty = d;
        tick();
        tick();
        check("rst led", 32'(bus.LED_out), 32'd0);
        check("rst step", 32'(bus.step), 32'd0);
        rst    = 1'b0;
        bus.EN = 1'b1;
    endtask

    task automatic hold_off(input string tag, input int n);
        for (int j = 0; j < n; j++) begin
            tick();
            check($sformatf("%s led j=%0d", tag, j), 32'(bus.LED_out), 32'd0);
            check($sformatf("%s step j=%0d", tag, j), 32'(bus.step), 32'd0);
        end
    endtask

    initial begin
        bus.EN   = 1'b0;
        bus.DIR  = 1'b0;
        bus.duty = 4'd3;

        // Basic flow from reset; in ping-pong builds DIR is toggled to show it is ignored.
        do_reset(1'b0, 4'd3);
        for (int i = 0; i < NP1; i++) begin
`ifdef LED_FLOW_PINGPONG_EN
            bus.DIR = i[0];
`endif
            cyc("t1", seq1[i], 3, 0, PERIOD - 1);
        end

`ifndef LED_FLOW_PINGPONG_EN
        // Downward stepping, then a mid-period DIR change that only bites at the wrap.
        do_reset(1'b1, 4'd3);
        for (int i = 0; i < 4; i++) begin
            cyc("t2", seq2[i], 3, 0, PERIOD - 1);
        end
        cyc("t2", 0, 3, 0, 4);
        bus.DIR = 1'b0;
        cyc("t2", 0, 3, 5, PERIOD - 1);
        cyc("t2", 1, 3, 0, PERIOD - 1);
`endif

        // Duty extremes and a mid-period duty write.
        do_reset(1'b0, 4'd3);
        bus.duty = 4'd0;
        cyc("t3", 0, 3, 0, PERIOD - 1);
        bus.duty = 4'd10;
        cyc("t3", 1, 0, 0, PERIOD - 1);
        bus.duty = 4'd15;
        cyc("t3", 2, 10, 0, PERIOD - 1);
        cyc("t3", 3, 15, 0, 3);
        bus.duty = 4'd5;
        cyc("t3", 3, 15, 4, PERIOD - 1);
        cyc("t3", P_AFTER3, 5, 0, PERIOD - 1);

        // Enable pause mid-period, then EN dropped on the wrap cycle.
        do_reset(1'b0, 4'd3);
        cyc("t4", 0, 3, 0, 5);
        bus.EN = 1'b0;
        hold_off("t4 pause", 7);
        bus.EN = 1'b1;
        cyc("t4", 0, 3, 6, PERIOD - 1);
        cyc("t4", 1, 3, 0, PERIOD - 2);
        bus.EN = 1'b0;
        hold_off("t4 wrapoff", 3);
        bus.EN = 1'b1;
        cyc("t4", 1, 3, PERIOD - 1, PERIOD - 1);
        cyc("t4", 2, 3, 0, PERIOD - 1);

        // Asynchronous reset while LED 2 is lit.
        do_reset(1'b0, 4'd3);
        bus.duty = 4'd7;
        cyc("t5", 0, 3, 0, PERIOD - 1);
        cyc("t5", 1, 7, 0, PERIOD - 1);
        cyc("t5", 2, 7, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t5 async led", 32'(bus.LED_out), 32'd0);
        check("t5 async step", 32'(bus.step), 32'd0);
        tick();
        rst = 1'b0;
        cyc("t5 post", 0, 3, 0, PERIOD - 1);
        cyc("t5 post", 1, 7, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
